// File: rtl/if_pkg.sv
// if_pkg: shared widths, fetch FSM states and queue entry layout for the fetch unit.
package if_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INST_BYTES = 32'd4;
  localparam int FIFO_DEPTH = 2;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} fetch_state_e;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: 2-entry {pc, inst} queue; head always in slot 0, flush beats push.
module fetch_fifo
  import if_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic                pop,
  input  logic                flush,
  input  logic [2*XLEN-1:0]   din,
  output logic [2*XLEN-1:0]   head,
  output logic                full,
  output logic                empty
);
  logic [2*XLEN-1:0] e0_q, e0_d, e1_q, e1_d;
  logic [1:0] cnt_q, cnt_d, cnt_pop;
  logic do_pop;
  assign full = cnt_q == 2'(FIFO_DEPTH);
  assign empty = cnt_q == 2'd0;
  assign head = e0_q;
  assign do_pop = pop && !empty;
  always_comb begin
    cnt_pop = cnt_q - {1'b0, do_pop};
    e0_d = do_pop ? e1_q : e0_q;
    e1_d = e1_q;
    cnt_d = cnt_pop;
    if (push && cnt_pop != 2'(FIFO_DEPTH)) begin
      e0_d = (cnt_pop == 2'd0) ? din : e0_d;
      e1_d = (cnt_pop == 2'd0) ? e1_q : din;
      cnt_d = cnt_pop + 2'd1;
    end
    if (flush) cnt_d = 2'd0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      e0_q <= '0;
      e1_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      e0_q <= e0_d;
      e1_q <= e1_d;
    end
  end
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC + single-outstanding ROM fetch, 2-entry output queue, jump redirect.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_i,
  output logic        rom_req_o,
  output logic [31:0] rom_addr_o,
  input  logic        rom_gnt_i,
  input  logic        rom_rvalid_i,
  input  logic [31:0] rom_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o
);
  fetch_state_e state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, req_pc_q, req_pc_d;
  logic discard_q, discard_d, push, pop, keep, space, full, empty;
  fetch_entry_t head;
  assign if_valid_o = !empty && !jump_en_i;
  assign pop = if_valid_o && !hold_i;
  assign if_pc_o = empty ? '0 : head.pc;
  assign if_inst_o = empty ? '0 : head.inst;
  assign rom_addr_o = pc_q;
  // a fetch still in flight, or landing in the queue this cycle, already holds a slot
  assign keep = state_q == WAIT && !(rom_rvalid_i && discard_q);
  assign space = keep ? (empty || (pop && !full)) : (!full || pop);
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    req_pc_d = req_pc_q;
    discard_d = discard_q;
    push = 1'b0;
    rom_req_o = 1'b0;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: rom_req_o = space && !jump_en_i;
      WAIT: begin
        push = rom_rvalid_i && !discard_q && !jump_en_i;
        discard_d = rom_rvalid_i ? 1'b0 : discard_q || jump_en_i;
        rom_req_o = rom_rvalid_i && space && !jump_en_i;
        state_d = rom_rvalid_i ? REQ : WAIT;
      end
      default: state_d = IDLE;
    endcase
    if (rom_req_o && rom_gnt_i) begin
      req_pc_d = pc_q;
      pc_d = pc_q + INST_BYTES;
      state_d = WAIT;
    end
    if (jump_en_i) pc_d = {jump_addr_i[XLEN-1:2], 2'b00};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      req_pc_q <= '0;
      discard_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      req_pc_q <= req_pc_d;
      discard_q <= discard_d;
    end
  end
  fetch_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (jump_en_i),
    .din   ({req_pc_q, rom_rdata_i}),
    .head  (head),
    .full  (full),
    .empty (empty)
  );
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: ROM responder + in-order scoreboard of granted addresses, scenario tasks.
module tb_if_fetch_unit;
  logic clk = 0, rst = 1, jump_en_i = 0, hold_i = 0, rom_gnt_i = 0, rom_rvalid_i = 0;
  logic [31:0] jump_addr_i = 0, rom_rdata_i = 0, rom_addr_o, if_pc_o, if_inst_o;
  logic rom_req_o, if_valid_o;
  int checks = 0, failures = 0, cyc = 0;
  int gnt_delay = 0, rv_delay = 1, req_cnt = 0, rv_cnt = 0;
  logic [31:0] pend_addr = 0;
  logic [31:0] exp_q[$];
  logic [31:0] pop_pc[$];
  int pop_cyc[$];

  if_fetch_unit dut (
    .clk(clk), .rst(rst), .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i), .hold_i(hold_i),
    .rom_req_o(rom_req_o), .rom_addr_o(rom_addr_o), .rom_gnt_i(rom_gnt_i),
    .rom_rvalid_i(rom_rvalid_i), .rom_rdata_i(rom_rdata_i),
    .if_valid_o(if_valid_o), .if_pc_o(if_pc_o), .if_inst_o(if_inst_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {pc[15:0], pc[31:16]} ^ 32'hC0DE_0013;
  endfunction

  // ROM: grant after gnt_delay cycles of steady req, data rv_delay cycles after grant
  always @(negedge clk) begin
    rom_rvalid_i = 0;
    rom_rdata_i = 32'hDEAD_BEEF;
    if (rv_cnt > 0) begin
      rv_cnt--;
      if (rv_cnt == 0) begin
        rom_rvalid_i = 1;
        rom_rdata_i = inst_of(pend_addr);
      end
    end
    #1;
    rom_gnt_i = 0;
    if (!rom_req_o) req_cnt = 0;
    else if (req_cnt >= gnt_delay) begin
      rom_gnt_i = 1;
      pend_addr = rom_addr_o;
      rv_cnt = rv_delay;
      req_cnt = 0;
    end else req_cnt++;
  end

  // scoreboard: granted addresses in order, flushed by jump/reset, checked on every pop
  always @(negedge clk) begin
    logic [31:0] e;
    #2;
    if (rst) exp_q.delete();
    else begin
      if (jump_en_i) exp_q.delete();
      if (if_valid_o && !hold_i) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected got pc=%h want=none", if_pc_o);
        end else begin
          e = exp_q.pop_front();
          if (if_pc_o !== e || if_inst_o !== inst_of(e)) begin
            failures++;
            $display("FAIL sb_order got pc=%h inst=%h want pc=%h inst=%h", if_pc_o, if_inst_o, e, inst_of(e));
          end
        end
        pop_pc.push_back(if_pc_o);
        pop_cyc.push_back(cyc);
      end
      if (rom_req_o && rom_gnt_i) exp_q.push_back(rom_addr_o);
    end
  end

  task automatic wait_grant(input bit any, input logic [31:0] addr);
    bit ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      #3;
      ok = rom_req_o && rom_gnt_i && (any || rom_addr_o == addr);
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL grant_timeout got=none want=grant addr %h", addr);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #3;
    checks++;
    if ({rom_req_o, if_valid_o} !== 2'b00 || rom_addr_o !== 32'h0 || if_pc_o !== 32'h0 || if_inst_o !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs got req=%b valid=%b addr=%h pc=%h inst=%h want all 0",
               rom_req_o, if_valid_o, rom_addr_o, if_pc_o, if_inst_o);
    end
    @(negedge clk);
    rst = 0;
    #3;
    checks++;
    if (rom_req_o !== 1'b0 || if_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL idle_cycle got req=%b valid=%b want 0 0", rom_req_o, if_valid_o);
    end
  endtask

  task automatic test_stream();
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      #3;
      if (c == 1) begin
        checks++;
        if (rom_req_o !== 1'b1 || rom_addr_o !== 32'h0) begin
          failures++;
          $display("FAIL first_req got req=%b addr=%h want 1 00000000", rom_req_o, rom_addr_o);
        end
      end
      checks++;
      if (if_valid_o !== (c >= 3)) begin
        failures++;
        $display("FAIL stream_valid c=%0d got=%b want=%b", c, if_valid_o, c >= 3);
      end
      if (c >= 3) begin
        checks++;
        if (if_pc_o !== 32'(4 * (c - 3)) || if_inst_o !== inst_of(32'(4 * (c - 3)))) begin
          failures++;
          $display("FAIL stream_data c=%0d got pc=%h inst=%h want pc=%h", c, if_pc_o, if_inst_o, 32'(4 * (c - 3)));
        end
      end
    end
  endtask

  task automatic test_hold();
    logic [31:0] last = pop_pc[$];
    pop_pc.delete();
    pop_cyc.delete();
    repeat (6) begin
      @(negedge clk);
      hold_i = 1;
      #3;
    end
    checks++;
    if (rom_req_o !== 1'b0 || if_valid_o !== 1'b1 || pop_pc.size() != 0) begin
      failures++;
      $display("FAIL hold_full got req=%b valid=%b pops=%0d want 0 1 0", rom_req_o, if_valid_o, pop_pc.size());
    end
    @(negedge clk);
    hold_i = 0;
    repeat (5) @(negedge clk);
    #3;
    checks++;
    if (pop_pc.size() != 6) begin
      failures++;
      $display("FAIL hold_release_count got=%0d want=6", pop_pc.size());
    end else
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (pop_pc[i] !== last + 32'(4 * (i + 1)) || (i > 0 && pop_cyc[i] != pop_cyc[i-1] + 1)) begin
          failures++;
          $display("FAIL hold_release_seq i=%0d got pc=%h want pc=%h one per cycle", i, pop_pc[i], last + 32'(4 * (i + 1)));
        end
      end
  endtask

  task automatic test_jump_wait();
    rv_delay = 3;
    wait_grant(1, 0);
    @(negedge clk);
    jump_en_i = 1;
    jump_addr_i = 32'h0000_0102;
    #3;
    checks++;
    if (if_valid_o !== 1'b0 || rom_req_o !== 1'b0) begin
      failures++;
      $display("FAIL jw_jump_cycle got valid=%b req=%b want 0 0", if_valid_o, rom_req_o);
    end
    @(negedge clk);
    jump_en_i = 0;
    #3;
    checks++;
    if (if_valid_o !== 1'b0 || rom_req_o !== 1'b0) begin
      failures++;
      $display("FAIL jw_flushed got valid=%b req=%b want 0 0", if_valid_o, rom_req_o);
    end
    @(negedge clk);
    rv_delay = 1;
    #3;
    checks++;
    if (rom_req_o !== 1'b1 || rom_addr_o !== 32'h100 || if_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL jw_stale_drop got req=%b addr=%h valid=%b want 1 00000100 0", rom_req_o, rom_addr_o, if_valid_o);
    end
    repeat (2) @(negedge clk);
    #3;
    checks++;
    if (if_valid_o !== 1'b1 || if_pc_o !== 32'h100) begin
      failures++;
      $display("FAIL jw_target got valid=%b pc=%h want 1 00000100", if_valid_o, if_pc_o);
    end
  endtask

  task automatic test_jump_rvalid();
    bit seen8 = 0;
    @(negedge clk);
    jump_en_i = 1;
    jump_addr_i = 32'h0;
    @(negedge clk);
    jump_en_i = 0;
    wait_grant(0, 32'h8);
    @(negedge clk);
    jump_en_i = 1;
    jump_addr_i = 32'h200;
    pop_pc.delete();
    #3;
    checks++;
    if (if_valid_o !== 1'b0 || rom_req_o !== 1'b0 || rom_rvalid_i !== 1'b1) begin
      failures++;
      $display("FAIL jr_jump_cycle got valid=%b req=%b rvalid=%b want 0 0 1", if_valid_o, rom_req_o, rom_rvalid_i);
    end
    @(negedge clk);
    jump_en_i = 0;
    #3;
    checks++;
    if (rom_req_o !== 1'b1 || rom_addr_o !== 32'h200) begin
      failures++;
      $display("FAIL jr_next_addr got req=%b addr=%h want 1 00000200", rom_req_o, rom_addr_o);
    end
    repeat (6) @(negedge clk);
    #3;
    foreach (pop_pc[i]) seen8 |= pop_pc[i] == 32'h8;
    checks++;
    if (pop_pc.size() == 0 || pop_pc[0] !== 32'h200 || seen8) begin
      failures++;
      $display("FAIL jr_dropped got first=%h seen8=%b want first=00000200 seen8=0",
               pop_pc.size() ? pop_pc[0] : 32'hx, seen8);
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    jump_en_i = 1;
    jump_addr_i = 32'hFFFF_FFFF;
    pop_pc.delete();
    @(negedge clk);
    jump_en_i = 0;
    repeat (6) @(negedge clk);
    #3;
    checks++;
    if (pop_pc.size() < 2 || pop_pc[0] !== 32'hFFFF_FFFC || pop_pc[1] !== 32'h0) begin
      failures++;
      $display("FAIL wrap got first=%h second=%h want FFFFFFFC 00000000",
               pop_pc.size() > 0 ? pop_pc[0] : 32'hx, pop_pc.size() > 1 ? pop_pc[1] : 32'hx);
    end
  endtask

  task automatic test_gnt_delay();
    @(negedge clk);
    jump_en_i = 1;
    jump_addr_i = 32'h300;
    gnt_delay = 3;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      jump_en_i = 0;
      #3;
      checks++;
      if (rom_req_o !== 1'b1 || rom_addr_o !== 32'h300 || rom_gnt_i !== (c == 4)) begin
        failures++;
        $display("FAIL gd_req_stable c=%0d got req=%b addr=%h gnt=%b want 1 00000300 %b",
                 c, rom_req_o, rom_addr_o, rom_gnt_i, c == 4);
      end
    end
    repeat (2) @(negedge clk);
    #3;
    checks++;
    if (if_valid_o !== 1'b1 || if_pc_o !== 32'h300) begin
      failures++;
      $display("FAIL gd_entry got valid=%b pc=%h want 1 00000300", if_valid_o, if_pc_o);
    end
    @(negedge clk);
    #3;
    checks++;
    if (if_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL gd_single got valid=%b want 0", if_valid_o);
    end
    @(negedge clk);
    gnt_delay = 0;
  endtask

  task automatic test_reset_wait();
    rv_delay = 2;
    wait_grant(1, 0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    rv_delay = 1;
    #3;
    checks++;
    if (rom_rvalid_i !== 1'b1 || if_valid_o !== 1'b0 || rom_req_o !== 1'b0) begin
      failures++;
      $display("FAIL rw_late_rvalid got rvalid=%b valid=%b req=%b want 1 0 0", rom_rvalid_i, if_valid_o, rom_req_o);
    end
    @(negedge clk);
    #3;
    checks++;
    if (rom_req_o !== 1'b1 || rom_addr_o !== 32'h0) begin
      failures++;
      $display("FAIL rw_restart got req=%b addr=%h want 1 00000000", rom_req_o, rom_addr_o);
    end
    repeat (2) @(negedge clk);
    #3;
    checks++;
    if (if_valid_o !== 1'b1 || if_pc_o !== 32'h0 || if_inst_o !== inst_of(32'h0)) begin
      failures++;
      $display("FAIL rw_first got valid=%b pc=%h inst=%h want 1 00000000 %h", if_valid_o, if_pc_o, if_inst_o, inst_of(32'h0));
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_hold();
    test_jump_wait();
    test_jump_rvalid();
    test_wrap();
    test_gnt_delay();
    test_reset_wait();
    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule
